// File: rtl/sha3_pkg.sv
`default_nettype none
// ============================================================================
// sha3_pkg : shared lane type and Keccak rate constants for the SHA3 datapath
// Revision : 1.0
// ============================================================================
package sha3_pkg;

  localparam int LANE_W = 64;

  // Rate in 64-bit lanes per SHA3 variant (1600-bit state minus capacity)
  localparam int RATE_LANES_224 = 18;
  localparam int RATE_LANES_256 = 17;
  localparam int RATE_LANES_384 = 13;
  localparam int RATE_LANES_512 = 9;

  typedef logic [LANE_W-1:0] lane_t;

endpackage : sha3_pkg
`default_nettype wire

// File: rtl/sha3_fifo_ram.sv
`default_nettype none
// ============================================================================
// sha3_fifo_ram : DEPTH x WIDTH storage, one synchronous write port and one
//                 registered read port (read data register is reset)
// Revision      : 1.0
// ============================================================================
module sha3_fifo_ram
  import sha3_pkg::*;
#(
  parameter int WIDTH = LANE_W,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // A read and a write to the same address return the old contents.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule : sha3_fifo_ram
`default_nettype wire

// File: rtl/sha3_lane_fifo.sv
`default_nettype none
// ============================================================================
// sha3_lane_fifo : lane FIFO between AXI slave and SHA3 core with occupancy
//                  count, almost-full, sticky OVF/UDF and synchronous flush
// Revision       : 1.0
// ============================================================================
module sha3_lane_fifo
  import sha3_pkg::*;
#(
  parameter int WIDTH     = LANE_W,
  parameter int DEPTH     = 32,
  parameter int AFULL_LVL = RATE_LANES_256
) (
  input  logic                     clk,
  input  logic                     RST,
  input  logic [WIDTH-1:0]         Din,
  input  logic                     Vin,
  input  logic                     RE,
  input  logic                     FLUSH,
  output logic [WIDTH-1:0]         Dout,
  output logic                     Dvalid,
  output logic [$clog2(DEPTH):0]   CNT,
  output logic                     FULL,
  output logic                     EMPTY,
  output logic                     AFULL,
  output logic                     OVF,
  output logic                     UDF
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] C_AFULL = CW'(AFULL_LVL);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dvalid_q, dvalid_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          rd_ok, wr_ok;
  logic          ram_we, ram_re;

  assign FULL  = (cnt_q == C_DEPTH);
  assign EMPTY = (cnt_q == '0);
  assign AFULL = (cnt_q >= C_AFULL);

  // A full FIFO can accept a write in the same cycle a read frees a slot.
  assign rd_ok = RE && !EMPTY;
  assign wr_ok = Vin && (!FULL || rd_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    dvalid_d = 1'b0;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    ram_we   = 1'b0;
    ram_re   = 1'b0;
    if (FLUSH) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (wr_ok) begin
        ram_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (rd_ok) begin
        ram_re   = 1'b1;
        dvalid_d = 1'b1;
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (Vin && !wr_ok) ovf_d = 1'b1;
      if (RE && EMPTY)   udf_d = 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      dvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      dvalid_q <= dvalid_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  sha3_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst_i   (RST),
    .we_i    (ram_we && !RST),
    .waddr_i (wr_ptr_q),
    .wdata_i (Din),
    .re_i    (ram_re),
    .raddr_i (rd_ptr_q),
    .rdata_o (Dout)
  );

  assign CNT    = cnt_q;
  assign Dvalid = dvalid_q;
  assign OVF    = ovf_q;
  assign UDF    = udf_q;

endmodule : sha3_lane_fifo
`default_nettype wire

// File: tb/tb_sha3_lane_fifo.sv
`default_nettype none
// ============================================================================
// tb_sha3_lane_fifo : directed scenarios plus random traffic against a
//                     queue-based reference model of the lane FIFO
// Revision          : 1.0
// ============================================================================
module tb_sha3_lane_fifo;

  localparam int WIDTH     = 64;
  localparam int DEPTH     = 32;
  localparam int AFULL_LVL = 17;
  localparam int CW        = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             RST = 1'b1;
  logic [WIDTH-1:0] Din = '0;
  logic             Vin = 1'b0;
  logic             RE = 1'b0;
  logic             FLUSH = 1'b0;
  logic [WIDTH-1:0] Dout;
  logic             Dvalid;
  logic [CW-1:0]    CNT;
  logic             FULL, EMPTY, AFULL, OVF, UDF;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic [WIDTH-1:0] m_q[$];
  logic [WIDTH-1:0] m_dout;
  logic             m_dvalid, m_ovf, m_udf;

  sha3_lane_fifo #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .AFULL_LVL (AFULL_LVL)
  ) dut (
    .clk    (clk),
    .RST    (RST),
    .Din    (Din),
    .Vin    (Vin),
    .RE     (RE),
    .FLUSH  (FLUSH),
    .Dout   (Dout),
    .Dvalid (Dvalid),
    .CNT    (CNT),
    .FULL   (FULL),
    .EMPTY  (EMPTY),
    .AFULL  (AFULL),
    .OVF    (OVF),
    .UDF    (UDF)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic rst, input logic flush, input logic vin,
                            input logic re, input logic [WIDTH-1:0] din);
    int  sz;
    bit  rd_ok, wr_ok;
    sz = m_q.size();
    if (rst) begin
      m_q.delete();
      m_dout = '0; m_dvalid = 0; m_ovf = 0; m_udf = 0;
    end else if (flush) begin
      m_q.delete();
      m_dvalid = 0;
    end else begin
      rd_ok = re && (sz > 0);
      wr_ok = vin && ((sz < DEPTH) || rd_ok);
      if (vin && !wr_ok) m_ovf = 1;
      if (re && sz == 0) m_udf = 1;
      m_dvalid = rd_ok;
      if (rd_ok) m_dout = m_q.pop_front();
      if (wr_ok) m_q.push_back(din);
    end
  endtask

  task automatic check_all();
    int sz;
    sz = m_q.size();
    chk("Dout",   Dout,   m_dout);
    chk("Dvalid", Dvalid, m_dvalid);
    chk("CNT",    CNT,    sz);
    chk("FULL",   FULL,   sz == DEPTH);
    chk("EMPTY",  EMPTY,  sz == 0);
    chk("AFULL",  AFULL,  sz >= AFULL_LVL);
    chk("OVF",    OVF,    m_ovf);
    chk("UDF",    UDF,    m_udf);
  endtask

  // one clock: apply inputs, advance model, compare just after the edge
  task automatic step(input logic rst, input logic flush, input logic vin,
                      input logic re, input logic [WIDTH-1:0] din);
    RST = rst; FLUSH = flush; Vin = vin; RE = re; Din = din;
    @(posedge clk);
    model_edge(rst, flush, vin, re, din);
    #1;
    check_all();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    int wr_pct, rd_pct;
    m_dout = '0; m_dvalid = 0; m_ovf = 0; m_udf = 0;

    // 1: reset, then a read of an empty FIFO
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, 1'b1, '0);
    chk("udf_after_empty_read", UDF, 1'b1);

    // 2: fill to full and overflow once
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 64'(i));
      if (i == AFULL_LVL - 1) chk("afull_at_17", AFULL, 1'b1);
      if (i == AFULL_LVL - 2) chk("afull_below_17", AFULL, 1'b0);
    end
    chk("full_at_32", FULL, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 64'hDEAD);
    chk("ovf_on_drop", OVF, 1'b1);
    chk("cnt_after_drop", CNT, 32);

    // 3: drain in order
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, '0);
      chk("drain_order", Dout, 64'(i));
    end
    idle();
    chk("empty_after_drain", EMPTY, 1'b1);

    // 4: full-throughput read+write across pointer wrap
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 64'(100 + i));
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, 64'(200 + i));
      chk("wrap_order", Dout, (i < DEPTH) ? 64'(100 + i) : 64'(200 + i - DEPTH));
    end
    chk("no_ovf_when_full_rw", OVF, 1'b0);

    // 5: flush with a concurrent write; OVF preserved
    step(1'b0, 1'b0, 1'b1, 1'b0, 64'hBAD);  // overflow while still full
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 64'(i));
    for (int i = 0; i < DEPTH - 5; i++) step(1'b0, 1'b0, 1'b0, 1'b1, '0);
    chk("cnt_before_flush", CNT, 5);
    step(1'b0, 1'b1, 1'b1, 1'b1, 64'h1234);
    chk("flush_empty", EMPTY, 1'b1);
    chk("flush_keeps_ovf", OVF, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 64'hCAFE_F00D);
    step(1'b0, 1'b0, 1'b0, 1'b1, '0);
    chk("post_flush_word", Dout, 64'hCAFE_F00D);

    // 6: reset mid-burst at CNT=10
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 64'(50 + i));
    step(1'b1, 1'b0, 1'b1, 1'b1, 64'h77);
    chk("rst_cnt", CNT, 0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 64'(i));
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, '0);
      chk("post_rst_order", Dout, 64'(i));
    end

    // random traffic with shifting read/write bias
    for (int ph = 0; ph < 8; ph++) begin
      wr_pct = (ph % 2 == 0) ? 80 : 30;
      rd_pct = (ph % 2 == 0) ? 30 : 80;
      for (int i = 0; i < 300; i++) begin
        step(($urandom_range(0, 299) == 0),
             ($urandom_range(0, 63) == 0),
             ($urandom_range(0, 99) < wr_pct),
             ($urandom_range(0, 99) < rd_pct),
             {$urandom, $urandom});
      end
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_sha3_lane_fifo
`default_nettype wire
